// File: rtl/stage_pkg.sv
// Shared definitions for the decode stage (stage1) and the execute stage (stage2).
// Contents:
//   - default data, register-file and counter widths
//   - instruction-class codes (opsel) and sub-operation codes
//   - instr_t: the 32-bit instruction word split into its fields
//   - opsel_legal(): tells whether stage2 implements an instruction class
package stage_pkg;

    localparam int DATA_W  = 32;
    localparam int NREG    = 8;
    localparam int CNT_W   = 16;
    localparam int INSTR_W = 32;

    localparam logic [2:0] OPSEL_SHIFT = 3'b000;
    localparam logic [2:0] OPSEL_ARITH = 3'b001;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } arith_op_e;

    typedef enum logic [2:0] {
        OP_SHL = 3'd0,
        OP_SHR = 3'd1,
        OP_SRA = 3'd2
    } shift_op_e;

    typedef struct packed {
        logic [2:0]  opsel;      // [31:29]
        logic [2:0]  operation;  // [28:26]
        logic        imm;        // [25]
        logic [2:0]  rd;         // [24:22]
        logic [2:0]  rs1;        // [21:19]
        logic [2:0]  rs2;        // [18:16]
        logic [15:0] imm16;      // [15:0]
    } instr_t;

    function automatic logic opsel_legal(input logic [2:0] opsel);
        return (opsel == OPSEL_SHIFT) || (opsel == OPSEL_ARITH);
    endfunction

endpackage

// File: rtl/stage1_regfile.sv
// Register file for the decode stage: NREG x DATA_W, two asynchronous
// read ports and one synchronous write port. Register 0 always reads as
// zero, and writes to it are dropped.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, clears every register
//   wr_en      in   write strobe
//   wr_addr    in   write address
//   wr_data    in   write data
//   rd_addr_a  in   read port A address
//   rd_data_a  out  read port A data
//   rd_addr_b  in   read port B address
//   rd_data_b  out  read port B data
module stage1_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Entry 0 is never written, but the read is gated as well so r0 is zero
    // by construction rather than by relying on reset.
    assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/stage1_decode.sv
// Decode / operand-fetch stage. Accepts 32-bit instructions on a
// valid/ready handshake, reads operands from the internal register file
// (with same-cycle write-back bypass) and registers the bundle that feeds
// the execute stage. Write-back from stage2 updates the register file on
// every cycle it is strobed, regardless of stall or accept.
// Ports:
//   CLOCK          in   rising-edge clock
//   RESET          in   synchronous active-high reset
//   instr_in       in   instruction word
//   instr_valid    in   instr_in is valid this cycle
//   instr_ready    out  stage can accept (low during RESET and stall)
//   stall_in       in   downstream hold request
//   wb_en          in   write-back strobe
//   wb_addr        in   write-back destination register
//   wb_data        in   write-back value
//   aluin1         out  operand A (rs1)
//   aluin2         out  operand B (rs2 or sign-extended imm16)
//   opselect_out   out  instruction class
//   operation_out  out  sub-operation within the class
//   shift_number   out  shift amount
//   enable_arith   out  valid arithmetic op in the bundle
//   enable_shift   out  valid shift op in the bundle
//   out_valid      out  bundle holds a decoded instruction
//   rd_out         out  destination register tag
//   illegal_op     out  one-cycle pulse for an accepted unsupported class
//   instr_count    out  accepted-instruction count, wraps
module stage1_decode #(
    parameter int DATA_W = stage_pkg::DATA_W,
    parameter int NREG   = stage_pkg::NREG,
    parameter int CNT_W  = stage_pkg::CNT_W
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [31:0]             instr_in,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic                    stall_in,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    output logic [DATA_W-1:0]       aluin1,
    output logic [DATA_W-1:0]       aluin2,
    output logic [2:0]              opselect_out,
    output logic [2:0]              operation_out,
    output logic [4:0]              shift_number,
    output logic                    enable_arith,
    output logic                    enable_shift,
    output logic                    out_valid,
    output logic [2:0]              rd_out,
    output logic                    illegal_op,
    output logic [CNT_W-1:0]        instr_count
);

    import stage_pkg::*;

    localparam int AW = $clog2(NREG);

    instr_t            instr;
    logic              accept;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b_reg;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        shamt;

    assign instr       = instr_t'(instr_in);
    assign instr_ready = ~stall_in & ~RESET;
    assign accept      = instr_valid & instr_ready;

    stage1_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk       (CLOCK),
        .rst       (RESET),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_addr_a (instr.rs1[AW-1:0]),
        .rd_data_a (rf_a),
        .rd_addr_b (instr.rs2[AW-1:0]),
        .rd_data_b (rf_b)
    );

    // A write-back landing this cycle has not reached the array yet, so
    // forward it; r0 is excluded because it must always read as zero.
    always_comb begin
        opnd_a     = rf_a;
        opnd_b_reg = rf_b;
        if (wb_en && (wb_addr == instr.rs1[AW-1:0]) && (instr.rs1 != '0)) begin
            opnd_a = wb_data;
        end
        if (wb_en && (wb_addr == instr.rs2[AW-1:0]) && (instr.rs2 != '0)) begin
            opnd_b_reg = wb_data;
        end
    end

    assign imm_ext = {{(DATA_W-16){instr.imm16[15]}}, instr.imm16};
    assign opnd_b  = instr.imm ? imm_ext : opnd_b_reg;
    assign shamt   = instr.imm ? instr.imm16[4:0] : opnd_b_reg[4:0];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            aluin1        <= '0;
            aluin2        <= '0;
            opselect_out  <= '0;
            operation_out <= '0;
            shift_number  <= '0;
            enable_arith  <= 1'b0;
            enable_shift  <= 1'b0;
            out_valid     <= 1'b0;
            rd_out        <= '0;
            illegal_op    <= 1'b0;
            instr_count   <= '0;
        end else if (stall_in) begin
            // Bundle frozen for the downstream stage; the illegal flag is an
            // event, not state, so it still drops after its single cycle.
            illegal_op <= 1'b0;
        end else if (accept) begin
            aluin1        <= opnd_a;
            aluin2        <= opnd_b;
            opselect_out  <= instr.opsel;
            operation_out <= instr.operation;
            shift_number  <= shamt;
            enable_arith  <= (instr.opsel == OPSEL_ARITH);
            enable_shift  <= (instr.opsel == OPSEL_SHIFT);
            out_valid     <= 1'b1;
            rd_out        <= instr.rd;
            illegal_op    <= ~opsel_legal(instr.opsel);
            instr_count   <= instr_count + CNT_W'(1);
        end else begin
            // Bubble: data outputs keep their last values.
            enable_arith <= 1'b0;
            enable_shift <= 1'b0;
            out_valid    <= 1'b0;
            illegal_op   <= 1'b0;
        end
    end

endmodule
